cpu_sequencer: RTL



---
 rtl/cpu_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/LOAD/EXEC control unit for the 16-bit-instruction ALU datapath.
// Define CPU_SEQUENCER_PERF_EN to add the retired/taken_br performance counters.
module cpu_sequencer #(
  parameter int PC_W  = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             imem_en,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [15:0]      imem_rdata,
  output logic [15:0]      instruction,
  output logic             write_en,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  output logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic             halted
`ifdef CPU_SEQUENCER_PERF_EN
  ,
  output logic [31:0]      retired,
  output logic [15:0]      taken_br
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     instr_q, instr_d;

  logic [1:0]      op_type;
  logic [1:0]      op_f;
  logic [3:0]      op_off;
  logic [7:0]      op_tgt;
  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] off_ext;
  logic [PC_W+7:0] tgt_wide;
  logic [PC_W-1:0] tgt_pc;
  logic            exec_we;
  logic            br_taken;
  logic            restart;

  assign op_type  = instr_q[15:14];
  assign op_f     = instr_q[1:0];
  assign op_off   = instr_q[13:10];
  assign op_tgt   = instr_q[13:6];
  assign pc_plus1 = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
  assign off_ext  = {{(PC_W-4){op_off[3]}}, op_off};
  // Widen then slice so the jump target zero-extends or truncates for any PC_W.
  assign tgt_wide = {{PC_W{1'b0}}, op_tgt};
  assign tgt_pc   = tgt_wide[PC_W-1:0];
  assign restart  = ((state_q == S_IDLE) || (state_q == S_HALT)) && start;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    exec_we  = 1'b0;
    br_taken = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        instr_d = imem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_plus1;
        case (op_type)
          2'b00, 2'b01: exec_we = 1'b1;
          2'b10: begin
            if ((op_f == 2'b00 && rd1 == rd2) || (op_f == 2'b01 && rd1 != rd2)) begin
              br_taken = 1'b1;
              pc_d     = pc_plus1 + off_ext;
            end
          end
          default: begin
            if (op_f == 2'b00) begin
              pc_d = tgt_pc;
            end else if (op_f == 2'b11) begin
              pc_d    = pc_q;
              state_d = S_HALT;
            end
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Gating with rst_n keeps a reset that lands mid-EXEC from committing the write.
  assign write_en    = exec_we & rst_n;
  assign imem_en     = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign busy        = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_EXEC);
  assign halted      = (state_q == S_HALT);

`ifdef CPU_SEQUENCER_PERF_EN
  logic [31:0] retired_q, retired_d;
  logic [15:0] taken_q, taken_d;

  always_comb begin
    retired_d = retired_q;
    taken_d   = taken_q;
    if (restart) begin
      retired_d = '0;
      taken_d   = '0;
    end else if (state_q == S_EXEC) begin
      if (retired_q != 32'hFFFF_FFFF) retired_d = retired_q + 32'd1;
      if (br_taken && taken_q != 16'hFFFF) taken_d = taken_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= '0;
      taken_q   <= '0;
    end else begin
      retired_q <= retired_d;
      taken_q   <= taken_d;
    end
  end

  assign retired  = retired_q;
  assign taken_br = taken_q;
`else
  logic unused_restart;
  assign unused_restart = restart | br_taken;
`endif

endmodule
